// File: rtl/qea_host_ctrl_if.sv
// Host-controller bundle: system command/stream ports plus the QEA ctx/state RAM ports.
// The controller takes the master view; the system side and QEA core take the slave view.
interface qea_host_ctrl_if #(
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16
);
  localparam int unsigned SW = PE_NUM * STATE_DATA_WIDTH;

  logic                               i_cmd_start;
  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num;
  logic                               i_ctx_valid;
  logic                               o_ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data;
  logic                               o_busy;
  logic                               o_done;
  logic                               o_err;
  logic [31:0]                        o_cycle_cnt;
  logic                               o_qea_start;
  logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num;
  logic                               o_qea_ctx_en;
  logic                               o_qea_ctx_wea;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_qea_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_qea_ctx_data;
  logic                               o_qea_state_ena;
  logic                               o_qea_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra;
  logic [SW-1:0]                      o_qea_state_dina;
  logic                               i_qea_complete;
  logic [SW-1:0]                      i_qea_state_dout;
  logic                               o_amp_valid;
  logic                               i_amp_ready;
  logic [SW-1:0]                      o_amp_data;
  logic                               o_amp_last;

  modport master (
    input  i_cmd_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data,
           i_qea_complete, i_qea_state_dout, i_amp_ready,
    output o_ctx_ready, o_busy, o_done, o_err, o_cycle_cnt, o_qea_start, o_qea_qbit_num,
           o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data,
           o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_state_dina,
           o_amp_valid, o_amp_data, o_amp_last
  );

  modport slave (
    output i_cmd_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data,
           i_qea_complete, i_qea_state_dout, i_amp_ready,
    input  o_ctx_ready, o_busy, o_done, o_err, o_cycle_cnt, o_qea_start, o_qea_qbit_num,
           o_qea_ctx_en, o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data,
           o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_state_dina,
           o_amp_valid, o_amp_data, o_amp_last
  );
endinterface

// File: rtl/qea_host_ctrl.sv
// QEA job sequencer: loads gate context, seeds |0..0>, starts the core, times it,
// then streams the full state vector out over a valid/ready port.
module qea_host_ctrl #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned NUM_FRAC_BIT            = 30,
  parameter int unsigned RD_LATENCY              = 1
) (
  input logic             clk,
  input logic             rst_n,
  qea_host_ctrl_if.master bus
);
  localparam int unsigned SW    = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned NW    = STATE_ADDR_WIDTH + 1;
  localparam int unsigned LOW_W = (PE_NUM - 1) * STATE_DATA_WIDTH;
  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned QW    = MAX_QBIT_WIDTH;
  localparam int unsigned SA    = STATE_ADDR_WIDTH;
  localparam int unsigned GA    = GATE_CONTEXT_ADDR_WIDTH;
  localparam int unsigned GD    = GATE_CONTEXT_DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] FIX_ONE  = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // Top lane of word 0 carries amplitude 1.0 + 0i; everything else starts at zero.
  localparam logic [SW-1:0]         ONE_WORD = {FIX_ONE, DATA_WIDTH'(0), LOW_W'(0)};

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_STATE, START, RUN, READ_REQ, READ_WAIT, READ_HOLD, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [GA-1:0]     ins_q, ins_d;
  logic [GA-1:0]     ctx_cnt_q, ctx_cnt_d;
  logic [SA-1:0]     last_q, last_d;
  logic [SA-1:0]     addr_q, addr_d;
  logic [LAT_W-1:0]  wait_q, wait_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              start_q, start_d;
  logic [QW-1:0]     qbit_q, qbit_d;
  logic              ctx_ready_q, ctx_ready_d;
  logic              ctx_en_q, ctx_en_d;
  logic [GA-1:0]     ctx_addr_q, ctx_addr_d;
  logic [GD-1:0]     ctx_data_q, ctx_data_d;
  logic              st_ena_q, st_ena_d;
  logic              st_wea_q, st_wea_d;
  logic [SA-1:0]     st_addr_q, st_addr_d;
  logic [SW-1:0]     st_din_q, st_din_d;
  logic              amp_valid_q, amp_valid_d;
  logic [SW-1:0]     amp_data_q, amp_data_d;
  logic              amp_last_q, amp_last_d;

  logic              bad_qbit;

  assign bad_qbit = (bus.i_qbit_num <= QW'(PE_NUM_WIDTH)) ||
                    (bus.i_qbit_num >  QW'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ctx_cnt_d   = ctx_cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cyc_d       = cyc_q;
    start_d     = 1'b0;
    qbit_d      = qbit_q;
    ctx_ready_d = 1'b0;
    ctx_en_d    = 1'b0;
    ctx_addr_d  = '0;
    ctx_data_d  = '0;
    st_ena_d    = 1'b0;
    st_wea_d    = 1'b0;
    st_addr_d   = '0;
    st_din_d    = '0;
    amp_valid_d = 1'b0;
    amp_data_d  = amp_data_q;
    amp_last_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_cmd_start) begin
          if (bad_qbit) begin
            err_d = 1'b1;
          end else begin
            qbit_d    = bus.i_qbit_num;
            ins_d     = bus.i_ins_num;
            last_d    = SA'((NW'(1) << (bus.i_qbit_num - QW'(PE_NUM_WIDTH))) - NW'(1));
            ctx_cnt_d = '0;
            addr_d    = '0;
            if (bus.i_ins_num != '0) begin
              ctx_ready_d = 1'b1;
              state_d     = LOAD_CTX;
            end else begin
              state_d = INIT_STATE;
            end
          end
        end
      end
      LOAD_CTX: begin
        ctx_ready_d = 1'b1;
        if (bus.i_ctx_valid && ctx_ready_q) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q;
          ctx_data_d = bus.i_ctx_data;
          ctx_cnt_d  = ctx_cnt_q + GA'(1);
          if (ctx_cnt_q == ins_q - GA'(1)) begin
            ctx_ready_d = 1'b0;
            state_d     = INIT_STATE;
          end
        end
      end
      INIT_STATE: begin
        st_ena_d  = 1'b1;
        st_wea_d  = 1'b1;
        st_addr_d = addr_q;
        st_din_d  = (addr_q == '0) ? ONE_WORD : '0;
        if (addr_q == last_q) begin
          addr_d  = '0;
          state_d = START;
        end else begin
          addr_d = addr_q + SA'(1);
        end
      end
      START: begin
        start_d = 1'b1;
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // The cycle that samples completion is itself counted.
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
        if (bus.i_qea_complete) state_d = READ_REQ;
      end
      READ_REQ: begin
        st_ena_d  = 1'b1;
        st_addr_d = addr_q;
        wait_d    = '0;
        state_d   = READ_WAIT;
      end
      READ_WAIT: begin
        // One extra cycle covers the registered read strobe before RAM latency starts.
        if (wait_q == LAT_W'(RD_LATENCY)) begin
          amp_valid_d = 1'b1;
          amp_data_d  = bus.i_qea_state_dout;
          amp_last_d  = (addr_q == last_q);
          state_d     = READ_HOLD;
        end else begin
          wait_d = wait_q + LAT_W'(1);
        end
      end
      READ_HOLD: begin
        if (amp_valid_q && bus.i_amp_ready) begin
          if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + SA'(1);
            state_d = READ_REQ;
          end
        end else begin
          amp_valid_d = 1'b1;
          amp_last_d  = amp_last_q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ins_q       <= '0;
      ctx_cnt_q   <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= '0;
      start_q     <= 1'b0;
      qbit_q      <= '0;
      ctx_ready_q <= 1'b0;
      ctx_en_q    <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_data_q  <= '0;
      st_ena_q    <= 1'b0;
      st_wea_q    <= 1'b0;
      st_addr_q   <= '0;
      st_din_q    <= '0;
      amp_valid_q <= 1'b0;
      amp_data_q  <= '0;
      amp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      ctx_cnt_q   <= ctx_cnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      start_q     <= start_d;
      qbit_q      <= qbit_d;
      ctx_ready_q <= ctx_ready_d;
      ctx_en_q    <= ctx_en_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_data_q  <= ctx_data_d;
      st_ena_q    <= st_ena_d;
      st_wea_q    <= st_wea_d;
      st_addr_q   <= st_addr_d;
      st_din_q    <= st_din_d;
      amp_valid_q <= amp_valid_d;
      amp_data_q  <= amp_data_d;
      amp_last_q  <= amp_last_d;
    end
  end

  assign bus.o_busy            = busy_q;
  assign bus.o_done            = done_q;
  assign bus.o_err             = err_q;
  assign bus.o_cycle_cnt       = cyc_q;
  assign bus.o_qea_start       = start_q;
  assign bus.o_qea_qbit_num    = qbit_q;
  assign bus.o_ctx_ready       = ctx_ready_q;
  assign bus.o_qea_ctx_en      = ctx_en_q;
  assign bus.o_qea_ctx_wea     = ctx_en_q;
  assign bus.o_qea_ctx_addr    = ctx_addr_q;
  assign bus.o_qea_ctx_data    = ctx_data_q;
  assign bus.o_qea_state_ena   = st_ena_q;
  assign bus.o_qea_state_wea   = st_wea_q;
  assign bus.o_qea_state_addra = st_addr_q;
  assign bus.o_qea_state_dina  = st_din_q;
  assign bus.o_amp_valid       = amp_valid_q;
  assign bus.o_amp_data        = amp_data_q;
  assign bus.o_amp_last        = amp_last_q;
endmodule

// File: tb/tb_qea_host_ctrl.sv
// Bench for qea_host_ctrl: job table plus an abort-by-reset sequence, with a stub QEA
// core and queue scoreboards for ctx writes, state writes and amplitude words.
module tb_qea_host_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qea_host_ctrl_if bus ();
  qea_host_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int qbit; int ins; int delay; bit force_c; bit gaps; bit bp; bit err; int exp_cnt;
  } vec_t;
  typedef struct { logic [15:0] a; logic [63:0]  d; } ctx_wr_t;
  typedef struct { logic [15:0] a; logic [255:0] d; } st_wr_t;
  typedef struct { logic [255:0] d; logic last; } amp_t;

  ctx_wr_t exp_ctx[$];
  st_wr_t  exp_st[$];
  amp_t    exp_amp[$];

  int checks = 0, failures = 0, cyc = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int ctx_wr_n = 0, ctx_first = 0, ctx_last = 0;
  int st_wr_n = 0, st_first = 0, st_last = 0;
  int delay = 2, timer = 0;
  bit force_c = 1'b0, bp = 1'b0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_dout(input logic [15:0] a);
    logic [255:0] w;
    for (int l = 0; l < 4; l++) w[l*64 +: 64] = {a, 8'(l), 8'hA5, 16'h0, ~a};
    return w;
  endfunction

  function automatic logic [1023:0] all_outs();
    return 1024'({bus.o_busy, bus.o_done, bus.o_err, bus.o_cycle_cnt, bus.o_qea_start,
                  bus.o_qea_qbit_num, bus.o_ctx_ready, bus.o_qea_ctx_en, bus.o_qea_ctx_wea,
                  bus.o_qea_ctx_addr, bus.o_qea_ctx_data, bus.o_qea_state_ena,
                  bus.o_qea_state_wea, bus.o_qea_state_addra, bus.o_qea_state_dina,
                  bus.o_amp_valid, bus.o_amp_data, bus.o_amp_last});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Stub QEA: completion arrives on the delay-th cycle counting the start pulse cycle as 1;
  // reads return a per-address pattern one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (!bus.o_busy)          timer <= 0;
    else if (bus.o_qea_start) timer <= 1;
    else if (timer != 0)      timer <= timer + 1;
    bus.i_qea_state_dout <= (bus.o_qea_state_ena && !bus.o_qea_state_wea)
                            ? mk_dout(bus.o_qea_state_addra) : {8{32'hDEADBEEF}};
  end
  assign bus.i_qea_complete = force_c || (timer != 0 && timer >= delay - 1);

  initial forever begin
    @(posedge clk); #1;
    bus.i_amp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Pulse counters and RAM write scoreboards.
  initial begin : wr_mon
    ctx_wr_t ce;
    st_wr_t  se;
    forever begin
      @(negedge clk);
      if (bus.o_qea_start) start_cnt++;
      if (bus.o_done) done_cnt++;
      if (bus.o_err) err_cnt++;
      if (bus.o_qea_ctx_en) begin
        chk("ctx_wea", 1024'(bus.o_qea_ctx_wea), 1);
        chk("ctx_write_expected", 1024'(exp_ctx.size() != 0), 1);
        if (exp_ctx.size() != 0) begin
          ce = exp_ctx.pop_front();
          chk("ctx_addr", 1024'(bus.o_qea_ctx_addr), 1024'(ce.a));
          chk("ctx_data", 1024'(bus.o_qea_ctx_data), 1024'(ce.d));
        end
        if (ctx_wr_n == 0) ctx_first = cyc;
        ctx_last = cyc;
        ctx_wr_n++;
      end
      if (bus.o_qea_state_ena && bus.o_qea_state_wea) begin
        chk("state_write_expected", 1024'(exp_st.size() != 0), 1);
        if (exp_st.size() != 0) begin
          se = exp_st.pop_front();
          chk("state_addr", 1024'(bus.o_qea_state_addra), 1024'(se.a));
          chk("state_data", 1024'(bus.o_qea_state_dina), 1024'(se.d));
        end
        if (st_wr_n == 0) st_first = cyc;
        st_last = cyc;
        st_wr_n++;
      end
    end
  end

  // Amplitude stream scoreboard with hold-stability checking under backpressure.
  initial begin : amp_mon
    amp_t e;
    logic [255:0] held_d;
    logic held_l;
    bit pend;
    pend = 1'b0; held_d = '0; held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("amp_valid_held", 1024'(bus.o_amp_valid), 1);
        chk("amp_data_stable", 1024'(bus.o_amp_data), 1024'(held_d));
        chk("amp_last_stable", 1024'(bus.o_amp_last), 1024'(held_l));
      end
      pend = 1'b0;
      if (bus.o_amp_valid) begin
        if (bus.i_amp_ready) begin
          chk("amp_expected", 1024'(exp_amp.size() != 0), 1);
          if (exp_amp.size() != 0) begin
            e = exp_amp.pop_front();
            chk("amp_data", 1024'(bus.o_amp_data), 1024'(e.d));
            chk("amp_last", 1024'(bus.o_amp_last), 1024'(e.last));
          end
        end else begin
          pend = 1'b1; held_d = bus.o_amp_data; held_l = bus.o_amp_last;
        end
      end
    end
  end

  task automatic push_job(input int n);
    logic [255:0] one_w;
    one_w = '0;
    one_w[255:192] = 64'h4000_0000_0000_0000;
    for (int a = 0; a < n; a++) begin
      exp_st.push_back('{a: 16'(a), d: (a == 0) ? one_w : 256'h0});
      exp_amp.push_back('{d: mk_dout(16'(a)), last: (a == n - 1)});
    end
  endtask

  task automatic pulse_cmd(input int qbit, input int ins);
    @(posedge clk); #1;
    bus.i_qbit_num = 6'(qbit); bus.i_ins_num = 16'(ins); bus.i_cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_start = 1'b0;
  endtask

  task automatic drive_ctx(input int n, input bit gaps);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 20000) begin
      @(posedge clk); #1;
      bus.i_ctx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_ctx_data = {$urandom, $urandom};
      @(negedge clk);
      if (bus.i_ctx_valid && bus.o_ctx_ready) begin
        exp_ctx.push_back('{a: 16'(k), d: bus.i_ctx_data});
        k++;
      end
      guard++;
    end
    @(posedge clk); #1;
    bus.i_ctx_valid = 1'b0;
    chk("ctx_beats_accepted", 1024'(k), 1024'(n));
  endtask

  task automatic run_job(input vec_t v);
    int n, budget, guard, s0, d0, e0;
    n = v.err ? 0 : (1 << (v.qbit - 2));
    delay = v.delay; force_c = v.force_c; bp = v.bp;
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    ctx_wr_n = 0; st_wr_n = 0;
    push_job(n);
    if (v.err || v.ins == 0) begin
      bus.i_ctx_valid = 1'b1;
      bus.i_ctx_data = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    pulse_cmd(v.qbit, v.ins);
    if (v.err) begin
      repeat (6) begin
        @(negedge clk);
        chk("err_busy_low", 1024'(bus.o_busy), 0);
      end
      chk("err_pulse", 1024'(err_cnt - e0), 1);
      chk("err_no_start", 1024'(start_cnt - s0), 0);
      bus.i_ctx_valid = 1'b0;
    end else begin
      if (v.ins > 0) drive_ctx(v.ins, v.gaps);
      budget = 2000 + n * 12 + v.delay;
      guard = 0;
      while (done_cnt == d0 && guard < budget) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      chk("job_done_pulse", 1024'(done_cnt - d0), 1);
      chk("cycle_cnt", 1024'(bus.o_cycle_cnt), 1024'(v.exp_cnt));
      chk("start_pulses", 1024'(start_cnt - s0), 1);
      chk("busy_after_done", 1024'(bus.o_busy), 0);
      chk("qbit_latched", 1024'(bus.o_qea_qbit_num), 1024'(v.qbit));
      chk("ctx_write_count", 1024'(ctx_wr_n), 1024'(v.ins));
      chk("state_write_count", 1024'(st_wr_n), 1024'(n));
      chk("init_span", 1024'(st_last - st_first), 1024'(n - 1));
      if (!v.gaps && v.ins > 0)
        chk("ctx_burst_span", 1024'(ctx_last - ctx_first), 1024'(v.ins - 1));
      chk("amp_words_left", 1024'(exp_amp.size()), 0);
      chk("state_writes_left", 1024'(exp_st.size()), 0);
      chk("ctx_writes_left", 1024'(exp_ctx.size()), 0);
      bus.i_ctx_valid = 1'b0;
      exp_amp.delete(); exp_st.delete(); exp_ctx.delete();
    end
  endtask

  initial begin : main
    int guard, d0;
    vec_t clean;
    vecs[0] = '{qbit: 15, ins: 363, delay: 100, force_c: 0, gaps: 0, bp: 0, err: 0, exp_cnt: 100};
    vecs[1] = '{qbit: 8,  ins: 40,  delay: 37,  force_c: 0, gaps: 1, bp: 1, err: 0, exp_cnt: 37};
    vecs[2] = '{qbit: 2,  ins: 5,   delay: 10,  force_c: 0, gaps: 0, bp: 0, err: 1, exp_cnt: 0};
    vecs[3] = '{qbit: 19, ins: 5,   delay: 10,  force_c: 0, gaps: 0, bp: 0, err: 1, exp_cnt: 0};
    vecs[4] = '{qbit: 3,  ins: 0,   delay: 10,  force_c: 0, gaps: 0, bp: 0, err: 0, exp_cnt: 10};
    vecs[5] = '{qbit: 5,  ins: 4,   delay: 50,  force_c: 1, gaps: 0, bp: 1, err: 0, exp_cnt: 1};
    vecs[6] = '{qbit: 4,  ins: 1,   delay: 2,   force_c: 0, gaps: 0, bp: 0, err: 0, exp_cnt: 2};
    clean   = '{qbit: 6,  ins: 7,   delay: 12,  force_c: 0, gaps: 1, bp: 1, err: 0, exp_cnt: 12};

    bus.i_cmd_start = 1'b0; bus.i_qbit_num = '0; bus.i_ins_num = '0;
    bus.i_ctx_valid = 1'b0; bus.i_ctx_data = '0; bus.i_amp_ready = 1'b1;

    #12;
    chk("reset_outputs_zero", all_outs(), 0);
    chk("reset_cycle_cnt", 1024'(bus.o_cycle_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 1024'(bus.o_busy), 0);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Abort in the middle of state initialisation, then run a clean job.
    delay = 20; force_c = 1'b0; bp = 1'b0;
    st_wr_n = 0;
    push_job(256);
    d0 = done_cnt;
    pulse_cmd(10, 0);
    guard = 0;
    while (st_wr_n < 20 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_init", 1024'(st_wr_n >= 20), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", all_outs(), 0);
    exp_st.delete(); exp_amp.delete(); exp_ctx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 1024'(done_cnt - d0), 0);
    chk("abort_idle", 1024'(bus.o_busy), 0);
    run_job(clean);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
